// File: rtl/gtfwizard_raw_gtwiz_buffbypass_tx_ctrl_if.sv
// gtfwizard_raw_gtwiz_buffbypass_tx_ctrl_if: GT status/strobe and controller status bundle
interface gtfwizard_raw_gtwiz_buffbypass_tx_ctrl_if #(parameter int N = 1);
  logic gtwiz_buffbypass_tx_start_user_in, gtwiz_buffbypass_tx_resetdone_in, rx_tx_rdy_in;
  logic [N-1:0] txphaligndone_in, txdlysresetdone_in, txphinitdone_in, txsyncdone_in;
  logic [N-1:0] txdlysreset_out, txphinit_out, txphalign_out, txdlyen_out;
  logic [N-1:0] txphalignen_out, txsyncmode_out, txsyncallin_out, txsyncin_out;
  logic [N-1:0] txphdlyreset_out, txphdlypd_out, txphovrden_out, txdlybypass_out, txdlyovrden_out;
  logic gtwiz_buffbypass_tx_done_out, gtwiz_buffbypass_tx_error_out;
  logic [3:0] retry_cnt_out;
  logic [2:0] sm_buffbypass_tx_out;
  modport slave (
    input gtwiz_buffbypass_tx_start_user_in, gtwiz_buffbypass_tx_resetdone_in, rx_tx_rdy_in,
    input txphaligndone_in, txdlysresetdone_in, txphinitdone_in, txsyncdone_in,
    output txdlysreset_out, txphinit_out, txphalign_out, txdlyen_out,
    output txphalignen_out, txsyncmode_out, txsyncallin_out, txsyncin_out,
    output txphdlyreset_out, txphdlypd_out, txphovrden_out, txdlybypass_out, txdlyovrden_out,
    output gtwiz_buffbypass_tx_done_out, gtwiz_buffbypass_tx_error_out, retry_cnt_out, sm_buffbypass_tx_out
  );
  modport master (
    output gtwiz_buffbypass_tx_start_user_in, gtwiz_buffbypass_tx_resetdone_in, rx_tx_rdy_in,
    output txphaligndone_in, txdlysresetdone_in, txphinitdone_in, txsyncdone_in,
    input txdlysreset_out, txphinit_out, txphalign_out, txdlyen_out,
    input txphalignen_out, txsyncmode_out, txsyncallin_out, txsyncin_out,
    input txphdlyreset_out, txphdlypd_out, txphovrden_out, txdlybypass_out, txdlyovrden_out,
    input gtwiz_buffbypass_tx_done_out, gtwiz_buffbypass_tx_error_out, retry_cnt_out, sm_buffbypass_tx_out
  );
endinterface

// File: rtl/gtfwizard_raw_gtwiz_buffbypass_tx_ctrl.sv
// gtfwizard_raw_gtwiz_buffbypass_tx_ctrl: TX buffer-bypass sequencer with per-step timeout and bounded retry
module gtfwizard_raw_gtwiz_buffbypass_tx_ctrl #(
  parameter int P_TOTAL_NUMBER_OF_CHANNELS = 1,
  parameter int P_MASTER_CHANNEL_POINTER = 0,
  parameter int P_MANUAL_MODE = 0,
  parameter int P_WAIT_RX_RDY = 1,
  parameter int P_TIMEOUT_CYCLES = 4096,
  parameter int P_MAX_RETRIES = 3
) (
  input logic gtwiz_buffbypass_tx_clk_in,
  input logic gtwiz_buffbypass_tx_reset_in,
  gtfwizard_raw_gtwiz_buffbypass_tx_ctrl_if.slave bb
);
  localparam int N = P_TOTAL_NUMBER_OF_CHANNELS;
  localparam int M = P_MASTER_CHANNEL_POINTER;
  localparam logic MAN = P_MANUAL_MODE != 0;
  typedef enum logic [2:0] {IDLE, WAIT_RX, DLYSRST, WAIT_SYNC, PHINIT, PHALIGN, DLYEN, DONE} state_t;
  logic clk, rst;
  state_t st_q, st_d;
  logic [3:0][4:0] sy_q, sy_d;
  logic [4:0] ed;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] rty_q, rty_d;
  logic pend_q, pend_d, dlysr_q, dlysr_d, phi_q, phi_d, pha_q, pha_d, dlyen_q, dlyen_d;
  logic done_q, done_d, err_q, err_d, step, tout, start;
  assign clk = gtwiz_buffbypass_tx_clk_in;
  assign rst = gtwiz_buffbypass_tx_reset_in;
  // bit map: 4 resetdone, 3 phaligndone, 2 dlysresetdone, 1 phinitdone, 0 syncdone
  always_comb sy_d = {sy_q[2:0], bb.gtwiz_buffbypass_tx_resetdone_in, bb.txphaligndone_in[M],
                      bb.txdlysresetdone_in[M], bb.txphinitdone_in[M], bb.txsyncdone_in[M]};
  assign ed = sy_q[2] & ~sy_q[3];
  assign step = st_q >= DLYSRST && st_q <= DLYEN;
  assign tout = step && cnt_q == 16'(P_TIMEOUT_CYCLES - 1);
  assign start = ed[4] || bb.gtwiz_buffbypass_tx_start_user_in;
  // three-stage synchroniser plus one edge-detect stage per status input
  always_ff @(posedge clk or posedge rst)
    if (rst) sy_q <= '0;
    else sy_q <= sy_d;
  // next state; an awaited edge beats a same-cycle timeout, and a retry inserts one all-strobes-low cycle
  always_comb begin
    st_d = st_q;
    cnt_d = '0;
    rty_d = rty_q;
    pend_d = 1'b0;
    dlysr_d = dlysr_q;
    phi_d = phi_q;
    pha_d = pha_q;
    dlyen_d = dlyen_q;
    done_d = done_q;
    err_d = err_q;
    if (pend_q) begin
      st_d = DLYSRST;
      dlysr_d = 1'b1;
    end else begin
      case (st_q)
        IDLE: if (start) begin
          done_d = 1'b0;
          err_d = 1'b0;
          rty_d = '0;
          st_d = P_WAIT_RX_RDY != 0 ? WAIT_RX : DLYSRST;
          dlysr_d = P_WAIT_RX_RDY == 0;
        end
        WAIT_RX: if (bb.rx_tx_rdy_in) begin
          st_d = DLYSRST;
          dlysr_d = 1'b1;
        end
        DLYSRST: if (ed[2]) begin
          dlysr_d = 1'b0;
          phi_d = MAN;
          st_d = MAN ? PHINIT : WAIT_SYNC;
        end
        WAIT_SYNC: if (ed[0]) st_d = DONE;
        PHINIT: if (ed[1]) begin
          phi_d = 1'b0;
          pha_d = 1'b1;
          st_d = PHALIGN;
        end
        PHALIGN: if (ed[3]) begin
          pha_d = 1'b0;
          dlyen_d = 1'b1;
          st_d = DLYEN;
        end
        DLYEN: if (ed[3]) begin
          dlyen_d = 1'b0;
          st_d = DONE;
        end
        default: begin
          done_d = 1'b1;
          err_d = ~sy_q[2][3];
          st_d = IDLE;
        end
      endcase
      if (tout && st_d == st_q) begin
        {dlysr_d, phi_d, pha_d, dlyen_d} = '0;
        pend_d = rty_q < 4'(P_MAX_RETRIES);
        rty_d = pend_d ? rty_q + 4'd1 : rty_q;
        done_d = done_d | ~pend_d;
        err_d = err_d | ~pend_d;
        st_d = pend_d ? st_q : IDLE;
      end else if (step && st_d == st_q) cnt_d = cnt_q + 16'd1;
    end
  end
  // FSM state and registered strobes/status
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      rty_q <= '0;
      {pend_q, dlysr_q, phi_q, pha_q, dlyen_q, done_q, err_q} <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      rty_q <= rty_d;
      {pend_q, dlysr_q, phi_q, pha_q, dlyen_q, done_q, err_q} <= {pend_d, dlysr_d, phi_d, pha_d, dlyen_d, done_d, err_d};
    end
  assign bb.txdlysreset_out = {N{dlysr_q}};
  assign bb.txphinit_out = {N{phi_q}};
  assign bb.txphalign_out = {N{pha_q}};
  assign bb.txdlyen_out = {N{dlyen_q}};
  assign bb.txphalignen_out = {N{MAN}};
  assign bb.txsyncmode_out = {N{~MAN}};
  assign bb.txsyncallin_out = bb.txphaligndone_in;
  assign bb.txsyncin_out = '0;
  assign bb.txphdlyreset_out = '0;
  assign bb.txphdlypd_out = '0;
  assign bb.txphovrden_out = '0;
  assign bb.txdlybypass_out = '0;
  assign bb.txdlyovrden_out = '0;
  assign bb.gtwiz_buffbypass_tx_done_out = done_q;
  assign bb.gtwiz_buffbypass_tx_error_out = err_q;
  assign bb.retry_cnt_out = rty_q;
  assign bb.sm_buffbypass_tx_out = st_q;
endmodule

// File: tb/tb_gtfwizard_raw_gtwiz_buffbypass_tx_ctrl.sv
// tb_gtfwizard_raw_gtwiz_buffbypass_tx_ctrl: randomized scoreboard bench for auto and manual controllers
module tb_gtfwizard_raw_gtwiz_buffbypass_tx_ctrl;
  localparam int T = 16, R = 3;
  typedef struct {logic err; logic [3:0] rty; int pulses;} exp_t;
  logic clk = 0, rsta = 1, rstm = 1;
  int total = 0, bad = 0;
  exp_t qa[$], qm[$];
  always #5 clk = ~clk;
  gtfwizard_raw_gtwiz_buffbypass_tx_ctrl_if #(.N(1)) ia();
  gtfwizard_raw_gtwiz_buffbypass_tx_ctrl_if #(.N(1)) im();
  gtfwizard_raw_gtwiz_buffbypass_tx_ctrl #(.P_TOTAL_NUMBER_OF_CHANNELS(1), .P_MASTER_CHANNEL_POINTER(0),
    .P_MANUAL_MODE(0), .P_WAIT_RX_RDY(1), .P_TIMEOUT_CYCLES(T), .P_MAX_RETRIES(R))
    ua (.gtwiz_buffbypass_tx_clk_in(clk), .gtwiz_buffbypass_tx_reset_in(rsta), .bb(ia));
  gtfwizard_raw_gtwiz_buffbypass_tx_ctrl #(.P_TOTAL_NUMBER_OF_CHANNELS(1), .P_MASTER_CHANNEL_POINTER(0),
    .P_MANUAL_MODE(1), .P_WAIT_RX_RDY(0), .P_TIMEOUT_CYCLES(T), .P_MAX_RETRIES(R))
    um (.gtwiz_buffbypass_tx_clk_in(clk), .gtwiz_buffbypass_tx_reset_in(rstm), .bb(im));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input int k, input logic phal);
    exp_t e;
    e.err = k > R || !phal;
    e.rty = 4'(k > R ? R : k);
    e.pulses = (k > R ? R : k) + 1;
    return e;
  endfunction
  function automatic logic [3:0] allow(input logic [2:0] s);
    return s == 2 ? 4'b1000 : s == 4 ? 4'b0100 : s == 5 ? 4'b0010 : s == 6 ? 4'b0001 : 4'b0000;
  endfunction
  task automatic score(input string nm, input exp_t e, input logic err, input logic [3:0] r, input int p, input logic [2:0] s);
    chk({nm, "_error"}, 32'(err), 32'(e.err));
    chk({nm, "_retry"}, 32'(r), 32'(e.rty));
    chk({nm, "_dlysreset_pulses"}, p, e.pulses);
    chk({nm, "_state_idle"}, 32'(s), 0);
  endtask
  logic pla = 0, pda = 0, plm = 0, pdm = 0;
  int npa = 0, npm = 0;
  always @(negedge clk) begin
    logic [3:0] sa;
    sa = {ia.txdlysreset_out[0], ia.txphinit_out[0], ia.txphalign_out[0], ia.txdlyen_out[0]};
    if (rsta) begin
      npa = 0; pla = 0; pda = 0;
    end else begin
      if (sa[3] && !pla) npa++;
      if (sa != 0) chk("a_strobe_outside_state", 32'(sa & ~allow(ia.sm_buffbypass_tx_out)), 0);
      if (ia.gtwiz_buffbypass_tx_done_out && !pda) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_done actual=done required=no_done");
        end else score("a", qa.pop_front(), ia.gtwiz_buffbypass_tx_error_out, ia.retry_cnt_out, npa, ia.sm_buffbypass_tx_out);
        npa = 0;
      end
      pla = sa[3]; pda = ia.gtwiz_buffbypass_tx_done_out;
    end
  end
  always @(negedge clk) begin
    logic [3:0] sm;
    sm = {im.txdlysreset_out[0], im.txphinit_out[0], im.txphalign_out[0], im.txdlyen_out[0]};
    if (rstm) begin
      npm = 0; plm = 0; pdm = 0;
    end else begin
      if (sm[3] && !plm) npm++;
      if (sm != 0) chk("m_strobe_outside_state", 32'(sm & ~allow(im.sm_buffbypass_tx_out)), 0);
      if (im.gtwiz_buffbypass_tx_done_out && !pdm) begin
        if (qm.size() == 0) begin
          total++; bad++;
          $display("FAIL m_unexpected_done actual=done required=no_done");
        end else score("m", qm.pop_front(), im.gtwiz_buffbypass_tx_error_out, im.retry_cnt_out, npm, im.sm_buffbypass_tx_out);
        npm = 0;
      end
      plm = sm[3]; pdm = im.gtwiz_buffbypass_tx_done_out;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic sig(input int sel);
    case (sel)
      0: return ia.txdlysreset_out[0];
      1: return im.txdlysreset_out[0];
      2: return im.txphinit_out[0];
      3: return im.txphalign_out[0];
      4: return im.txdlyen_out[0];
      5: return ia.gtwiz_buffbypass_tx_done_out;
      default: return im.gtwiz_buffbypass_tx_done_out;
    endcase
  endfunction
  task automatic waitfor(input string nm, input int sel, input logic v);
    int n = 0;
    while (sig(sel) !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel) !== v) begin
      total++; bad++;
      $display("FAIL wait_%s actual=%b required=%b", nm, sig(sel), v);
    end
  endtask
  task automatic run_auto(input int k, input logic phal, input logic usr, input logic ign);
    qa.push_back(model(k, phal));
    ia.txphaligndone_in = phal;
    if (usr) begin
      ia.gtwiz_buffbypass_tx_start_user_in = 1; cyc(1); ia.gtwiz_buffbypass_tx_start_user_in = 0;
    end else begin
      ia.gtwiz_buffbypass_tx_resetdone_in = 0; cyc(5); ia.gtwiz_buffbypass_tx_resetdone_in = 1;
    end
    cyc($urandom_range(12, 30));
    ia.rx_tx_rdy_in = 1; cyc(1); ia.rx_tx_rdy_in = 0;
    for (int a = 0; a <= R; a++) begin
      waitfor("a_dlysreset_rise", 0, 1);
      ia.txdlysresetdone_in = 0; ia.txsyncdone_in = 0;
      cyc($urandom_range(2, 4)); ia.txdlysresetdone_in = 1;
      waitfor("a_dlysreset_fall", 0, 0);
      if (a >= k) begin
        if (ign) begin
          ia.gtwiz_buffbypass_tx_start_user_in = 1; cyc(1); ia.gtwiz_buffbypass_tx_start_user_in = 0;
          chk("a_start_ignored_state", 32'(ia.sm_buffbypass_tx_out), 3);
        end
        cyc($urandom_range(1, 3)); ia.txsyncdone_in = 1;
        break;
      end
    end
    waitfor("a_done", 5, 1);
    cyc(3);
  endtask
  task automatic run_manual(input int k);
    qm.push_back(model(k, 1'b1));
    im.gtwiz_buffbypass_tx_start_user_in = 1; cyc(1); im.gtwiz_buffbypass_tx_start_user_in = 0;
    for (int a = 0; a <= R; a++) begin
      waitfor("m_dlysreset_rise", 1, 1);
      im.txdlysresetdone_in = 0; im.txphinitdone_in = 0; im.txphaligndone_in = 0;
      cyc($urandom_range(2, 4)); im.txdlysresetdone_in = 1;
      waitfor("m_phinit_rise", 2, 1);
      if (a >= k) begin
        cyc($urandom_range(1, 3)); im.txphinitdone_in = 1;
        waitfor("m_phalign_rise", 3, 1);
        cyc($urandom_range(1, 3)); im.txphaligndone_in = 1;
        waitfor("m_dlyen_rise", 4, 1);
        im.txphaligndone_in = 0; cyc(4); im.txphaligndone_in = 1;
        break;
      end
    end
    waitfor("m_done", 6, 1);
    cyc(3);
  endtask
  initial begin
    ia.gtwiz_buffbypass_tx_start_user_in = 0; ia.gtwiz_buffbypass_tx_resetdone_in = 0; ia.rx_tx_rdy_in = 0;
    ia.txphaligndone_in = 0; ia.txdlysresetdone_in = 0; ia.txphinitdone_in = 0; ia.txsyncdone_in = 0;
    im.gtwiz_buffbypass_tx_start_user_in = 0; im.gtwiz_buffbypass_tx_resetdone_in = 0; im.rx_tx_rdy_in = 0;
    im.txphaligndone_in = 1; im.txdlysresetdone_in = 0; im.txphinitdone_in = 0; im.txsyncdone_in = 0;
    cyc(3);
    rsta = 0; rstm = 0;
    cyc(1);
    chk("rst_state", 32'(ia.sm_buffbypass_tx_out), 0);
    chk("rst_done", 32'(ia.gtwiz_buffbypass_tx_done_out), 0);
    chk("rst_error", 32'(ia.gtwiz_buffbypass_tx_error_out), 0);
    chk("rst_retry", 32'(ia.retry_cnt_out), 0);
    chk("rst_strobes", 32'({ia.txdlysreset_out, ia.txphinit_out, ia.txphalign_out, ia.txdlyen_out}), 0);
    chk("auto_syncmode", 32'(ia.txsyncmode_out), 1);
    chk("auto_phalignen", 32'(ia.txphalignen_out), 0);
    chk("man_syncmode", 32'(im.txsyncmode_out), 0);
    chk("man_phalignen", 32'(im.txphalignen_out), 1);
    chk("man_syncallin", 32'(im.txsyncallin_out), 1);
    chk("auto_syncallin", 32'(ia.txsyncallin_out), 0);
    chk("tied_zero", 32'({ia.txsyncin_out, ia.txphdlyreset_out, ia.txphdlypd_out, ia.txphovrden_out,
                          ia.txdlybypass_out, ia.txdlyovrden_out}), 0);
    run_auto(0, 1, 0, 0);
    run_manual(0);
    run_auto(2, 1, 1, 0);
    run_auto(4, 1, 1, 0);
    run_auto(0, 0, 1, 1);
    run_manual(1);
    im.gtwiz_buffbypass_tx_start_user_in = 1; cyc(1); im.gtwiz_buffbypass_tx_start_user_in = 0;
    waitfor("r_dlysreset_rise", 1, 1);
    im.txdlysresetdone_in = 0; im.txphinitdone_in = 0; im.txphaligndone_in = 0;
    cyc(3); im.txdlysresetdone_in = 1;
    waitfor("r_phinit_rise", 2, 1);
    cyc(2); im.txphinitdone_in = 1;
    waitfor("r_phalign_rise", 3, 1);
    #2 rstm = 1;
    #1;
    chk("rst_async_phalign", 32'(im.txphalign_out), 0);
    chk("rst_async_done", 32'(im.gtwiz_buffbypass_tx_done_out), 0);
    chk("rst_async_state", 32'(im.sm_buffbypass_tx_out), 0);
    cyc(2);
    rstm = 0;
    cyc(2);
    run_manual(0);
    repeat (8) run_auto($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    repeat (3) run_manual($urandom_range(0, 4));
    cyc(5);
    chk("auto_queue_drained", qa.size(), 0);
    chk("man_queue_drained", qm.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gtfwizard_raw_gtwiz_buffbypass_tx_ctrl.md
Name: gtfwizard_raw_gtwiz_buffbypass_tx_ctrl

Overview:
TX-side buffer-bypass controller for the GTF raw wizard. It is the transmit counterpart of the RX buffer-bypass controller.
- Sequences TXDLYSRESET, then TXSYNCDONE (auto mode), or TXPHINIT/TXPHALIGN/TXDLYEN (manual mode) on the master channel.
- Optionally holds off until the RX controller issues its common-clock tx_rdy pulse.
- Adds per-step timeouts with bounded retries, and reports done/error to the top-level reset logic.

Parameters:
P_TOTAL_NUMBER_OF_CHANNELS, 1, number of GT channels driven.
P_MASTER_CHANNEL_POINTER, 0, index of the master channel whose status is monitored.
P_MANUAL_MODE, 0, 0 selects the auto sequence; 1 selects the manual sequence.
P_WAIT_RX_RDY, 1, 1 waits for rx_tx_rdy_in before starting; 0 skips that wait.
P_TIMEOUT_CYCLES, 4096, cycles allowed per step before a retry; range 2..65535.
P_MAX_RETRIES, 3, retries before declaring error; range 0..15.

Ports:
- gtwiz_buffbypass_tx_clk_in  in  1  sole clock (TXUSRCLK2 domain).
- gtwiz_buffbypass_tx_reset_in  in  1  asynchronous, active-high reset.
- gtwiz_buffbypass_tx_start_user_in  in  1  synchronous level; restarts the sequence from IDLE.
- gtwiz_buffbypass_tx_resetdone_in  in  1  async TX reset-done.
- rx_tx_rdy_in  in  1  one-cycle pulse from the RX controller, same clock.
- txphaligndone_in  in  N  async, per channel.
- txdlysresetdone_in  in  N  async, per channel.
- txphinitdone_in  in  N  async, per channel.
- txsyncdone_in  in  N  async, per channel.
- txdlysreset_out, txphinit_out, txphalign_out, txdlyen_out  out  N  sequencer strobes, identical on all channels.
- txphalignen_out, txsyncmode_out, txsyncallin_out, txsyncin_out  out  N  mode ties.
- txphdlyreset_out, txphdlypd_out, txphovrden_out, txdlybypass_out, txdlyovrden_out  out  N  tied 0.
- gtwiz_buffbypass_tx_done_out  out  1  sequence finished; sticky.
- gtwiz_buffbypass_tx_error_out  out  1  failure indication; sticky.
- retry_cnt_out  out  4  retries consumed in the current run.
- sm_buffbypass_tx_out  out  3  debug FSM state.

Behaviour:
Reset and clocking:
- Clocking and reset: one clock; reset is asynchronous and active-high (gtwiz_buffbypass_tx_clk_in, gtwiz_buffbypass_tx_reset_in).
- Reset clears the FSM to IDLE and sets all strobes, done, error, retry_cnt and the timeout counter to 0.
- Reset asserted mid-sequence immediately drops every strobe; there is no graceful completion.

Input synchronisation:
- resetdone and the master channel's phaligndone, dlysresetdone, phinitdone and syncdone each pass through a 3-FF synchroniser.
- Each synchronised input then feeds a 1-FF rising-edge detector.
- The synchroniser FFs reset to 0.

Mode ties:
- txphalignen = P_MANUAL_MODE.
- txsyncmode = ~P_MANUAL_MODE.
- txsyncallin = txphaligndone_in.
- txsyncin = 0.

Start condition:
- start = rising edge of synchronised resetdone, OR start_user_in = 1.
- start is honoured only in IDLE. It is ignored in every other state.

Timeout and retry rules:
- A 16-bit timeout counter clears on every state entry and increments each cycle in states 2, 3, 4, 5 and 6.
- Timeout occurs when counter = P_TIMEOUT_CYCLES-1.
- On timeout with retry_cnt < P_MAX_RETRIES: retry_cnt increments, all strobes go to 0 for one cycle, then the FSM enters DLYSRESET.
- On timeout with retry_cnt = P_MAX_RETRIES: done=1, error=1, FSM goes to IDLE.
- If the awaited edge and the timeout occur in the same cycle, the edge wins.

FSM states:
- 0 IDLE: on start, clear done, error and retry_cnt. Go to 1 if P_WAIT_RX_RDY=1, else to 2.
- 1 WAIT_RX_RDY: on rx_tx_rdy_in=1 go to 2. No timeout applies here.
- 2 DLYSRESET: txdlysreset=1 on entry. On dlysresetdone rising edge, txdlysreset=0 on the next cycle; go to 3 (auto) or 4 (manual).
- 3 WAIT_SYNCDONE (auto): on syncdone rising edge go to 7.
- 4 PHINIT (manual): txphinit=1. On phinitdone rising edge, txphinit=0; go to 5.
- 5 PHALIGN (manual): txphalign=1. On phaligndone rising edge, txphalign=0; go to 6.
- 6 DLYEN (manual): txdlyen=1. On the next phaligndone rising edge, txdlyen=0; go to 7.
- 7 DONE: done<=1; error <= ~synchronised phaligndone. Go to IDLE next cycle.

Done/error lifetime:
- done and error hold until the next honoured start or reset.

Latency:
- A strobe asserts on the first cycle of its state.
- A strobe deasserts 1 cycle after the edge is detected, which is 4–5 cycles after the raw GT status rises.

Test Plan:
- Auto mode, P_WAIT_RX_RDY=1: raise resetdone, pulse rx_tx_rdy 20 cycles later, return dlysresetdone and then syncdone, phaligndone=1 -> state path 0,1,2,3,7,0; txdlysreset high only in state 2; done=1, error=0, retry_cnt=0.
- Manual mode: return phinitdone, then phaligndone, drop it, then phaligndone again -> strobes txphinit, txphalign, txdlyen asserted in turn and never overlapping; done=1, error=0.
- P_TIMEOUT_CYCLES=16, syncdone withheld on the first two attempts -> retry_cnt=2, txdlysreset re-pulsed twice, then done=1, error=0.
- syncdone never returned, P_MAX_RETRIES=3 -> after 4×16 cycles in steps, done=1, error=1, FSM in IDLE, retry_cnt=3.
- Async reset asserted while in PHALIGN (manual) -> txphalign=0 in the same cycle, with no clock edge needed; done=0; state=0.
- start_user_in pulsed while in state 3 -> ignored. Then syncdone arrives with phaligndone=0 -> done=1, error=1.
